// File: rtl/jogo_pkg.sv
// jogo_pkg: state codes, default timings and timer sizing shared by the memory game datapath.
package jogo_pkg;

   typedef enum logic [3:0] {
      INICIAL  = 4'h0,
      ENDERECA = 4'h1,
      ACENDE   = 4'h2,
      APAGA    = 4'h3,
      PROXIMO  = 4'h4,
      FIM      = 4'hF
   } estado_t;

   localparam int T_ON_PADRAO  = 50_000_000;
   localparam int T_OFF_PADRAO = 25_000_000;

   // At least one bit, so that T_ON = T_OFF = 1 still yields a legal counter.
   function automatic int largura_timer(input int a, input int b);
      int m;
      m = a > b ? a : b;
      return m < 2 ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/contador_tempo.sv
// contador_tempo: up counter that wraps after reaching ultimo; fim flags the terminal count.
module contador_tempo #(
   parameter int W = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   input  logic [W-1:0] ultimo,
   output logic         fim
);

   logic [W-1:0] valor;

   assign fim = valor == ultimo;

   always_ff @(posedge clock or negedge reset)
      if (!reset) valor <= '0;
      else if (zera) valor <= '0;
      else if (conta) valor <= fim ? '0 : valor + 1'b1;

endmodule

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays ROM entries 0..limite on the leds, T_ON lit then T_OFF dark each, then pulses pronto.
module exibe_sequencia
   import jogo_pkg::*;
#(
   parameter int T_ON  = T_ON_PADRAO,
   parameter int T_OFF = T_OFF_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] limite,
   input  logic [3:0] dado,
   output logic [3:0] endereco,
   output logic [3:0] leds,
   output logic       exibindo,
   output logic       pronto,
   output logic [3:0] db_estado
);

   localparam int W = largura_timer(T_ON, T_OFF);
   localparam logic [W-1:0] ULT_ON  = W'(T_ON - 1);
   localparam logic [W-1:0] ULT_OFF = W'(T_OFF - 1);

   estado_t    estado, estado_n;
   logic [3:0] endereco_n, leds_n, lim, lim_n;
   logic       zera, conta, fim;

   // One shared timer; only the terminal value changes between lit and dark phases.
   contador_tempo #(.W(W)) u_timer (
      .clock  (clock),
      .reset  (reset),
      .zera   (zera),
      .conta  (conta),
      .ultimo (estado == APAGA ? ULT_OFF : ULT_ON),
      .fim    (fim)
   );

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         estado   <= INICIAL;
         endereco <= '0;
         leds     <= '0;
         lim      <= '0;
      end else begin
         estado   <= estado_n;
         endereco <= endereco_n;
         leds     <= leds_n;
         lim      <= lim_n;
      end

   always_comb begin
      estado_n   = estado;
      endereco_n = endereco;
      leds_n     = leds;
      lim_n      = lim;
      zera       = 1'b0;
      conta      = 1'b0;
      case (estado)
         INICIAL: begin
            zera = 1'b1;
            if (iniciar) begin
               endereco_n = '0;
               lim_n      = limite;
               estado_n   = ENDERECA;
            end
         end
         ENDERECA: begin
            zera     = 1'b1;
            leds_n   = dado;
            estado_n = ACENDE;
         end
         ACENDE: begin
            conta = 1'b1;
            if (fim) begin
               zera     = 1'b1;
               leds_n   = '0;
               estado_n = APAGA;
            end
         end
         APAGA: begin
            conta = 1'b1;
            if (fim) begin
               zera     = 1'b1;
               estado_n = PROXIMO;
            end
         end
         // Strict compare keeps endereco from ever wrapping past limite.
         PROXIMO: begin
            if (endereco < lim) begin
               endereco_n = endereco + 4'd1;
               estado_n   = ENDERECA;
            end else estado_n = FIM;
         end
         FIM:     estado_n = INICIAL;
         default: estado_n = INICIAL;
      endcase
   end

   assign exibindo  = estado != INICIAL && estado != FIM;
   assign pronto    = estado == FIM;
   assign db_estado = estado;

endmodule
